uart_apb_fifo_regs: RTL and testbench

- APB slave register file for the UART; successor to the single-byte buffer register block.
- Adds parametrised TX and RX FIFOs, a baud divisor register, a control register and a live status register with sticky error flags.
- Sits between the APB bus and the UART TX/RX cores.
- Read data is combinational in the access phase, so the core samples it in the same cycle.

---
 rtl/uart_apb_fifo_regs.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_apb_fifo_regs.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_fifo_regs.sv
// uart_apb_fifo_regs: APB slave register file for the UART.
// Holds TX/RX circular FIFOs, the baud divisor, the control register and the
// live/sticky status register. Read data and slave error are combinational in
// the APB access phase; every transfer completes with zero wait states.
// Optional interrupt output: define UART_APB_IRQ_EN to add the Irq port and the
// CTRL[6:4] interrupt enables.
module uart_apb_fifo_regs #(
  parameter int               DATA_W   = 8,
  parameter int               TX_DEPTH = 8,
  parameter int               RX_DEPTH = 8,
  parameter int               DIV_W    = 16,
  parameter logic [DIV_W-1:0] DIV_RST  = DIV_W'(104)
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              pSel,
  input  logic              pEnable,
  input  logic              pWrite,
  input  logic [31:0]       pAddr,
  input  logic [31:0]       pWdata,
  output logic [31:0]       pReadData,
  output logic              pSlvErr,
  output logic [DATA_W-1:0] TxData,
  output logic              TxValid,
  input  logic              TxReady,
  input  logic              RxDone,
  input  logic [DATA_W-1:0] RxData,
  output logic [DIV_W-1:0]  BaudDiv,
  output logic              RxEnable
`ifdef UART_APB_IRQ_EN
  ,
  output logic              Irq
`endif
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  localparam logic [7:0] A_TXDATA = 8'h00;
  localparam logic [7:0] A_RXDATA = 8'h01;
  localparam logic [7:0] A_BAUD   = 8'h02;
  localparam logic [7:0] A_CTRL   = 8'h03;
  localparam logic [7:0] A_STATUS = 8'h05;

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic       acc, wr_acc, rd_acc;
  logic [7:0] addr;
  logic       hit_tx, hit_rx, hit_baud, hit_ctrl, hit_stat, mapped;

  assign acc      = pSel & pEnable;
  assign wr_acc   = acc & pWrite;
  assign rd_acc   = acc & ~pWrite;
  assign addr     = pAddr[7:0];
  assign hit_tx   = (addr == A_TXDATA);
  assign hit_rx   = (addr == A_RXDATA);
  assign hit_baud = (addr == A_BAUD);
  assign hit_ctrl = (addr == A_CTRL);
  assign hit_stat = (addr == A_STATUS);
  assign mapped   = hit_tx | hit_rx | hit_baud | hit_ctrl | hit_stat;
  assign pSlvErr  = acc & ~mapped;

  // Upper address bits and unused write-data bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{pAddr[31:8], pWdata};

  // ---------------------------------------------------------------------------
  // Control / baud registers
  // ---------------------------------------------------------------------------
  logic             txen_q, txen_d, rxen_q, rxen_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic             tx_flush, rx_flush;
  logic [2:0]       ie_q;

  assign tx_flush = wr_acc & hit_ctrl & pWdata[2];
  assign rx_flush = wr_acc & hit_ctrl & pWdata[3];
  assign txen_d   = (wr_acc & hit_ctrl) ? pWdata[0] : txen_q;
  assign rxen_d   = (wr_acc & hit_ctrl) ? pWdata[1] : rxen_q;
  assign baud_d   = (wr_acc & hit_baud) ? pWdata[DIV_W-1:0] : baud_q;

  // Control and baud state; flush bits are one-shot and never stored.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      txen_q <= 1'b0;
      rxen_q <= 1'b0;
      baud_q <= DIV_RST;
    end else begin
      txen_q <= txen_d;
      rxen_q <= rxen_d;
      baud_q <= baud_d;
    end
  end

`ifdef UART_APB_IRQ_EN
  logic [2:0] ie_d;
  assign ie_d = (wr_acc & hit_ctrl) ? pWdata[6:4] : ie_q;

  // Interrupt enables: RXNEIE, TXEIE, ERRIE.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) ie_q <= 3'b000;
    else         ie_q <= ie_d;
  end
`else
  assign ie_q = 3'b000;
`endif

  assign BaudDiv  = baud_q;
  assign RxEnable = rxen_q;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TAW:0]      tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_cnt;
  logic              tx_empty, tx_full, tx_push_req, tx_push, tx_pop, tx_ovr_set;
  logic [DATA_W-1:0] tx_head;

  assign tx_cnt      = tx_wr_q - tx_rd_q;
  assign tx_empty    = (tx_wr_q == tx_rd_q);
  assign tx_full     = (tx_cnt == (TAW+1)'(TX_DEPTH));
  assign tx_head     = tx_empty ? '0 : tx_mem[tx_rd_q[TAW-1:0]];
  assign TxValid     = ~tx_empty & txen_q;
  assign TxData      = tx_head;
  assign tx_pop      = TxValid & TxReady;
  assign tx_push_req = wr_acc & hit_tx;
  // A same-cycle pop frees a slot, so a push at full is still accepted.
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovr_set  = tx_push_req & tx_full & ~tx_pop;
  assign tx_wr_d     = tx_flush ? '0 : tx_wr_q + (TAW+1)'(tx_push);
  assign tx_rd_d     = tx_flush ? '0 : tx_rd_q + (TAW+1)'(tx_pop);

  // TX pointers; flush overrides any same-cycle push/pop.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
    end
  end

  // TX storage write.
  always_ff @(posedge pClk) begin
    if (tx_push) tx_mem[tx_wr_q[TAW-1:0]] <= pWdata[DATA_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RAW:0]      rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_cnt;
  logic              rx_empty, rx_full, rx_push_req, rx_push, rx_pop, rx_rd_req;
  logic              rx_ovr_set, rx_udr_set;
  logic [DATA_W-1:0] rx_head;

  assign rx_cnt      = rx_wr_q - rx_rd_q;
  assign rx_empty    = (rx_wr_q == rx_rd_q);
  assign rx_full     = (rx_cnt == (RAW+1)'(RX_DEPTH));
  assign rx_head     = rx_empty ? '0 : rx_mem[rx_rd_q[RAW-1:0]];
  assign rx_rd_req   = rd_acc & hit_rx;
  assign rx_pop      = rx_rd_req & ~rx_empty;
  assign rx_udr_set  = rx_rd_req & rx_empty;
  assign rx_push_req = RxDone & rxen_q;
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign rx_ovr_set  = rx_push_req & rx_full & ~rx_pop;
  assign rx_wr_d     = rx_flush ? '0 : rx_wr_q + (RAW+1)'(rx_push);
  assign rx_rd_d     = rx_flush ? '0 : rx_rd_q + (RAW+1)'(rx_pop);

  // RX pointers; flush overrides any same-cycle push/pop.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
    end
  end

  // RX storage write.
  always_ff @(posedge pClk) begin
    if (rx_push) rx_mem[rx_wr_q[RAW-1:0]] <= RxData;
  end

  // ---------------------------------------------------------------------------
  // Status: live bits plus W1C sticky errors (a set event beats a clear)
  // ---------------------------------------------------------------------------
  logic rxovr_q, rxovr_d, txovr_q, txovr_d, rxudr_q, rxudr_d;
  logic w1c;
  logic st_rxne, st_txe, st_txnf, st_rxf;
  logic [31:0] status;

  assign w1c     = wr_acc & hit_stat;
  assign rxovr_d = (rxovr_q & ~(w1c & pWdata[4])) | rx_ovr_set;
  assign txovr_d = (txovr_q & ~(w1c & pWdata[5])) | tx_ovr_set;
  assign rxudr_d = (rxudr_q & ~(w1c & pWdata[6])) | rx_udr_set;

  // Sticky error flags.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      rxovr_q <= 1'b0;
      txovr_q <= 1'b0;
      rxudr_q <= 1'b0;
    end else begin
      rxovr_q <= rxovr_d;
      txovr_q <= txovr_d;
      rxudr_q <= rxudr_d;
    end
  end

  assign st_rxne = ~rx_empty;
  assign st_txe  = tx_empty;
  assign st_txnf = ~tx_full;
  assign st_rxf  = rx_full;
  assign status  = {8'h00, 8'(tx_cnt), 8'(rx_cnt), 1'b0, rxudr_q, txovr_q,
                    rxovr_q, st_rxf, st_txnf, st_txe, st_rxne};

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  // Combinational read data, zero outside a mapped read access.
  always_comb begin
    pReadData = '0;
    if (rd_acc) begin
      case (addr)
        A_TXDATA: pReadData = 32'(tx_head);
        A_RXDATA: pReadData = 32'(rx_head);
        A_BAUD:   pReadData = 32'(baud_q);
        A_CTRL:   pReadData = 32'({ie_q, 2'b00, rxen_q, txen_q});
        A_STATUS: pReadData = status;
        default:  pReadData = '0;
      endcase
    end
  end

`ifdef UART_APB_IRQ_EN
  // ---------------------------------------------------------------------------
  // Interrupt
  // ---------------------------------------------------------------------------
  logic irq_q, irq_d;
  assign irq_d = (st_rxne & ie_q[0]) | (st_txe & ie_q[1]) |
                 ((rxovr_q | txovr_q | rxudr_q) & ie_q[2]);

  // Registered interrupt, one cycle behind its condition.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) irq_q <= 1'b0;
    else         irq_q <= irq_d;
  end

  assign Irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_apb_fifo_regs.sv
// Testbench for uart_apb_fifo_regs: directed APB/UART stimulus with
// scoreboard queues for read data and TX beats, checked by monitor processes.
module tb_uart_apb_fifo_regs;

  logic        pClk = 1'b0;
  logic        pReset = 1'b0;
  logic        pSel = 1'b0, pEnable = 1'b0, pWrite = 1'b0;
  logic [31:0] pAddr = '0, pWdata = '0;
  logic [31:0] pReadData;
  logic        pSlvErr;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady = 1'b0;
  logic        RxDone = 1'b0;
  logic [7:0]  RxData = '0;
  logic [15:0] BaudDiv;
  logic        RxEnable;
`ifdef UART_APB_IRQ_EN
  logic        Irq;
`endif

  uart_apb_fifo_regs dut (
    .pClk(pClk), .pReset(pReset), .pSel(pSel), .pEnable(pEnable),
    .pWrite(pWrite), .pAddr(pAddr), .pWdata(pWdata),
    .pReadData(pReadData), .pSlvErr(pSlvErr),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
    .RxDone(RxDone), .RxData(RxData), .BaudDiv(BaudDiv), .RxEnable(RxEnable)
`ifdef UART_APB_IRQ_EN
    , .Irq(Irq)
`endif
  );

  always #5 pClk = ~pClk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [15:0] id;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         rd_id = 0;

  // Read monitor: compares every read access against the next expectation.
  always @(negedge pClk) begin
    if (pSel && pEnable && !pWrite) begin
      n_chk++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: addr 0x%02h data 0x%08h, no expectation", pAddr[7:0], pReadData);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        if (pReadData !== e.data || pSlvErr !== e.err) begin
          n_fail++;
          $display("FAIL read%0d addr 0x%02h: got data 0x%08h err %0b, expected data 0x%08h err %0b",
                   e.id, pAddr[7:0], pReadData, pSlvErr, e.data, e.err);
        end
      end
    end
  end

  // TX monitor: compares every accepted TX beat against the expected byte order.
  always @(negedge pClk) begin
    if (TxValid && TxReady) begin
      n_chk++;
      if (tx_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: TxData 0x%02h, no expectation", TxData);
      end else begin
        logic [7:0] e;
        e = tx_q.pop_front();
        if (TxData !== e) begin
          n_fail++;
          $display("FAIL tx_beat: got 0x%02h expected 0x%02h", TxData, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d,
                           input bit rdy_acc = 1'b0, input bit rxd_acc = 1'b0);
    @(posedge pClk); #1;
    pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddr = {24'h0, a}; pWdata = d;
    @(posedge pClk); #1;
    pEnable = 1'b1;
    if (rdy_acc) TxReady = 1'b1;
    if (rxd_acc) RxDone = 1'b1;
    @(posedge pClk); #1;
    pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    if (rdy_acc) TxReady = 1'b0;
    if (rxd_acc) RxDone = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [31:0] exp, input logic err = 1'b0);
    rd_exp_t e;
    e.data = exp; e.err = err; e.id = 16'(rd_id);
    rd_id++;
    rd_q.push_back(e);
    @(posedge pClk); #1;
    pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddr = {24'h0, a};
    @(posedge pClk); #1;
    pEnable = 1'b1;
    @(posedge pClk); #1;
    pSel = 1'b0; pEnable = 1'b0;
  endtask

  task automatic rx_burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pClk); #1;
      RxDone = 1'b1; RxData = first + 8'(i);
    end
    @(posedge pClk); #1;
    RxDone = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) @(posedge pClk);
    #1 pReset = 1'b1;
    chk("rst_TxValid", 32'(TxValid), 32'h0);
    chk("rst_TxData", 32'(TxData), 32'h0);
    chk("rst_BaudDiv", 32'(BaudDiv), 32'd104);
    chk("rst_RxEnable", 32'(RxEnable), 32'h0);
    chk("rst_ReadData_idle", pReadData, 32'h0);
    apb_read(8'h05, 32'h0000_0006);
    apb_read(8'h02, 32'd104);
    apb_read(8'h03, 32'h0);

    // TX path: three bytes held with TxReady low, then drained
    apb_write(8'h03, 32'h1);
    for (int i = 0; i < 3; i++) begin
      apb_write(8'h00, 32'h41 + i);
      tx_q.push_back(8'h41 + 8'(i));
    end
    apb_read(8'h05, 32'h0003_0004);
    chk("tx_head_data", 32'(TxData), 32'h41);
    chk("tx_head_valid", 32'(TxValid), 32'h1);
    apb_read(8'h00, 32'h41);
    TxReady = 1'b1;
    repeat (3) @(posedge pClk);
    #1 TxReady = 1'b0;
    chk("tx_drained_valid", 32'(TxValid), 32'h0);
    apb_read(8'h05, 32'h0000_0006);

    // RX ignored while RXEN=0
    rx_burst(8'hEE, 1);
    apb_read(8'h05, 32'h0000_0006);

    // RX fill past depth, drain, underflow, W1C
    apb_write(8'h03, 32'h3);
    chk("rxenable_on", 32'(RxEnable), 32'h1);
    rx_burst(8'h10, 9);
    apb_read(8'h05, 32'h0000_081F);
    for (int i = 0; i < 8; i++) apb_read(8'h01, 32'h10 + i);
    apb_read(8'h01, 32'h0);
    apb_read(8'h05, 32'h0000_0056);
    apb_write(8'h05, 32'h70);
    apb_read(8'h05, 32'h0000_0006);

    // TX fill to full, push with simultaneous pop, then overflow
    for (int i = 0; i < 8; i++) begin
      apb_write(8'h00, 32'h80 + i);
      tx_q.push_back(8'h80 + 8'(i));
    end
    apb_read(8'h05, 32'h0008_0000);
    apb_write(8'h00, 32'h88, 1'b1, 1'b0);
    tx_q.push_back(8'h88);
    apb_read(8'h05, 32'h0008_0000);
    apb_write(8'h00, 32'h99);
    apb_read(8'h05, 32'h0008_0020);

    // Clearing TXEN drops TxValid but retains contents
    apb_write(8'h03, 32'h2);
    chk("txen_off_valid", 32'(TxValid), 32'h0);
    rx_burst(8'h60, 2);
    apb_read(8'h05, 32'h0008_0221);

    // Unmapped address
    apb_read(8'h04, 32'h0, 1'b1);

    // Flush both FIFOs; sticky TXOVR survives
    apb_write(8'h03, 32'hC);
    tx_q.delete();
    apb_read(8'h05, 32'h0000_0026);
    apb_read(8'h03, 32'h0);

    // W1C racing an overflow set: set wins for RXOVR
    apb_write(8'h03, 32'h2);
    rx_burst(8'h20, 8);
    apb_read(8'h05, 32'h0000_082F);
    RxData = 8'h5A;
    apb_write(8'h05, 32'h30, 1'b0, 1'b1);
    apb_read(8'h05, 32'h0000_081F);

`ifdef UART_APB_IRQ_EN
    apb_write(8'h03, 32'h1A);
    apb_read(8'h03, 32'h12);
    chk("irq_idle", 32'(Irq), 32'h0);
    @(posedge pClk); #1;
    RxDone = 1'b1; RxData = 8'h33;
    @(posedge pClk); #1;
    RxDone = 1'b0;
    chk("irq_1cyc", 32'(Irq), 32'h0);
    @(posedge pClk); #1;
    chk("irq_2cyc", 32'(Irq), 32'h1);
    apb_read(8'h01, 32'h33);
    chk("irq_pop_same", 32'(Irq), 32'h1);
    @(posedge pClk); #1;
    chk("irq_pop_clear", 32'(Irq), 32'h0);
`else
    apb_write(8'h03, 32'h72);
    apb_read(8'h03, 32'h02);
`endif

    repeat (2) @(posedge pClk);
    #1;
    chk("rd_queue_empty", 32'(rd_q.size()), 32'h0);
    chk("tx_queue_empty", 32'(tx_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
